// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment display path: scan phases,
// the blank pattern and hex glyphs (segment order gfedcba, 1 = segment lit).
package seg7_pkg;

  typedef enum logic {
    SCAN_BLANK = 1'b0,
    SCAN_ON    = 1'b1
  } scan_state_t;

  localparam logic [7:0] SEG_OFF = 8'h00;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  // Lookup used by the result formatters upstream of the scanner.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
    logic [6:0] g;
    case (nibble)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = GLYPH_A;
      4'hB: g = GLYPH_B;
      4'hC: g = GLYPH_C;
      4'hD: g = GLYPH_D;
      4'hE: g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Per-slot timing: optional BLANK phase followed by the ON dwell window.
// Exposes both the current and the upcoming phase/count so the top can register outputs.
module seg7_slot_timer
  import seg7_pkg::*;
#(
  parameter int DWELL_CYCLES = 30000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W        = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output scan_state_t      phase,
  output logic [CNT_W-1:0] count,
  output scan_state_t      next_phase,
  output logic [CNT_W-1:0] next_count,
  output logic             slot_first,
  output logic             slot_done,
  output logic             last_cycle
);

  // With no blank window every slot starts directly in ON.
  localparam scan_state_t      FIRST_PHASE = (BLANK_CYCLES > 0) ? SCAN_BLANK : SCAN_ON;
  localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL_CYCLES - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= FIRST_PHASE;
      count <= '0;
    end else begin
      phase <= next_phase;
      count <= next_count;
    end
  end

  always_comb begin
    next_phase = phase;
    next_count = count;
    if (!enable) begin
      next_phase = FIRST_PHASE;
      next_count = '0;
    end else if (phase == SCAN_BLANK) begin
      if (count == BLANK_LAST) begin
        next_phase = SCAN_ON;
        next_count = '0;
      end else begin
        next_count = count + CNT_W'(1);
      end
    end else begin
      if (count == DWELL_LAST) begin
        next_phase = FIRST_PHASE;
        next_count = '0;
      end else begin
        next_count = count + CNT_W'(1);
      end
    end
  end

  assign slot_first = (phase == FIRST_PHASE) && (count == '0);
  assign slot_done  = (phase == SCAN_ON) && (count == DWELL_LAST);
  assign last_cycle = (next_phase == SCAN_ON) && (next_count == DWELL_LAST);

endmodule

// File: rtl/seg7_scan_driver.sv
// Common-anode multi-digit scanner: blank gap, per-digit enable, PWM brightness,
// and a once-per-frame snapshot of the inputs so a frame never tears.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SEG_W        = 7,
  parameter int DWELL_CYCLES = 30000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BRIGHT_W     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]       digit_en,
  input  logic [BRIGHT_W-1:0]         brightness,
  output logic [NUM_DIGITS-1:0]       an_n,
  output logic [SEG_W-1:0]            seg,
  output logic                        frame_tick
);

  localparam int MAX_CNT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PROD_W  = CNT_W + BRIGHT_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 1) begin : g_bad_num_digits
    $error("seg7_scan_driver: NUM_DIGITS must be >= 1");
  end
  if (DWELL_CYCLES < 1) begin : g_bad_dwell
    $error("seg7_scan_driver: DWELL_CYCLES must be >= 1");
  end

  scan_state_t       phase, next_phase;
  logic [CNT_W-1:0]  count, next_count;
  logic              slot_first, slot_done, last_cycle;

  logic [IDX_W-1:0]            idx, next_idx;
  logic [NUM_DIGITS*SEG_W-1:0] seg_snap, eff_seg;
  logic [NUM_DIGITS-1:0]       en_snap, eff_en;
  logic [BRIGHT_W-1:0]         bright_snap, eff_bright;
  logic                        capture;
  logic [BRIGHT_W:0]           duty_level;
  logic [PROD_W-1:0]           duty_prod, on_cycles;
  logic                        duty_on;
  logic [NUM_DIGITS-1:0]       an_n_d;
  logic [SEG_W-1:0]            seg_d;
  logic                        tick_d;

  seg7_slot_timer #(
    .DWELL_CYCLES(DWELL_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES),
    .CNT_W       (CNT_W)
  ) u_slot_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .phase     (phase),
    .count     (count),
    .next_phase(next_phase),
    .next_count(next_count),
    .slot_first(slot_first),
    .slot_done (slot_done),
    .last_cycle(last_cycle)
  );

  // The first cycle of digit 0's slot latches the inputs; the outputs being
  // prepared on that same edge already need the fresh values, hence the bypass.
  assign capture    = enable && slot_first && (idx == '0);
  assign eff_seg    = capture ? seg_in     : seg_snap;
  assign eff_en     = capture ? digit_en   : en_snap;
  assign eff_bright = capture ? brightness : bright_snap;

  always_comb begin
    next_idx = idx;
    if (!enable) begin
      next_idx = '0;
    end else if (slot_done) begin
      next_idx = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    end
  end

  assign duty_level = {1'b0, eff_bright} + (BRIGHT_W + 1)'(1);
  assign duty_prod  = PROD_W'(DWELL_CYCLES) * PROD_W'(duty_level);
  assign on_cycles  = duty_prod >> BRIGHT_W;
  assign duty_on    = enable && (next_phase == SCAN_ON) && (PROD_W'(next_count) < on_cycles);

  // Outputs are decoded for the cycle being entered, then registered.
  always_comb begin
    an_n_d = '1;
    seg_d  = SEG_OFF[SEG_W-1:0];
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (duty_on && eff_en[d] && (IDX_W'(d) == next_idx)) begin
        an_n_d[d] = 1'b0;
        seg_d     = eff_seg[d*SEG_W +: SEG_W];
      end
    end
  end

  assign tick_d = enable && last_cycle && (next_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      seg_snap    <= '0;
      en_snap     <= '0;
      bright_snap <= '0;
      an_n        <= '1;
      seg         <= '0;
      frame_tick  <= 1'b0;
    end else begin
      idx        <= next_idx;
      an_n       <= an_n_d;
      seg        <= seg_d;
      frame_tick <= tick_d;
      if (capture) begin
        seg_snap    <= seg_in;
        en_snap     <= digit_en;
        bright_snap <= brightness;
      end
    end
  end

endmodule
